// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory port around the arbiter.
// Pure wiring; adds no latency.
// Requesters hold req until their ready pulse; the memory request is held until mem_ready or timeout.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  // shared memory port
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side: serves the requesters, drives the memory port
  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rdata, d_err,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  // environment side: requesters and memory model
  modport master (
    output i_req, i_addr,
    input  i_ready, i_rdata, i_err,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rdata, d_err,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with round-robin ties and a wait watchdog.
// Latency: grant edge -> mem_valid next cycle; mem_ready edge -> one-cycle ready pulse (2 cycles zero-wait).
// Backpressure: requests wait in IDLE while halt is high or the port is busy; mem_ready low stretches the access up to TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  output logic              idle,
  mem_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  // last wait-counter value before the abort; the abort edge is the TIMEOUT-th edge without mem_ready
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BUS_I = 3'b010,
    BUS_D = 3'b100
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: load/store won the most recent grant
  logic [7:0]        cnt_q, cnt_d;

  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

  logic              i_ready_q, i_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              i_err_q, i_err_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic              i_elig;
  logic              d_elig;
  logic              pick_d;
  logic              timeout_hit;

  // A requester in its ready cycle still holds req for the transaction just served; ignore it.
  always_comb begin
    i_elig      = bus.i_req && !i_ready_q;
    d_elig      = bus.d_req && !d_ready_q;
    pick_d      = d_elig && (!i_elig || !last_d_q);
    timeout_hit = (cnt_q == CNT_LAST);
  end

  // Next-state, grant, completion and abort decisions.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    i_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    i_err_d     = i_err_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;

    unique case (state_q)
      IDLE: begin
        if (!halt && (i_elig || d_elig)) begin
          last_d_d    = pick_d;
          cnt_d       = 8'd0;
          mem_valid_d = 1'b1;
          if (pick_d) begin
            state_d     = BUS_D;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_wstrb_d = bus.d_wstrb;
          end else begin
            state_d     = BUS_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end
      end

      BUS_I: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          i_ready_d   = 1'b1;
          i_rdata_d   = bus.mem_rdata;
          i_err_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (timeout_hit) begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            i_ready_d   = 1'b1;
            i_rdata_d   = '0;
            i_err_d     = 1'b1;
          end
        end
      end

      BUS_D: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          d_ready_d   = 1'b1;
          d_rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
          d_err_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (timeout_hit) begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            d_ready_d   = 1'b1;
            d_rdata_d   = '0;
            d_err_d     = 1'b1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // Control registers; reset leaves the first tie to fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  // Registered memory request and requester responses; reset drops any in-flight access silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      i_err_q     <= 1'b0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      i_ready_q   <= i_ready_d;
      i_rdata_q   <= i_rdata_d;
      i_err_q     <= i_err_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  // Output drive straight from flops.
  always_comb begin
    bus.mem_valid = mem_valid_q;
    bus.mem_we    = mem_we_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.mem_wstrb = mem_wstrb_q;
    bus.i_ready   = i_ready_q;
    bus.i_rdata   = i_rdata_q;
    bus.i_err     = i_err_q;
    bus.d_ready   = d_ready_q;
    bus.d_rdata   = d_rdata_q;
    bus.d_err     = d_err_q;
    idle          = (state_q == IDLE) && !i_ready_q && !d_ready_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, async reset sequence, random run vs model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Requesters hold their request until the ready pulse; memory answers with random wait states.
module tb_mem_port_arbiter;

  localparam int TMO  = 4;
  localparam int NROW = 34;

  logic clk = 1'b0;
  logic reset;
  logic halt;
  logic idle;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .halt  (halt),
    .idle  (idle),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        halt;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mv;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wd;
    logic        e_ir;
    logic        e_dr;
    logic [31:0] e_rd;
    logic        e_err;
    logic        e_idle;
  } vec_t;

  vec_t tbl [NROW];

  // ---------------- reference model (transaction level) ----------------
  int          m_owner;      // 0 none, 1 fetch, 2 load/store
  int          m_elapsed;    // edges seen without mem_ready in the current access
  bit          m_last_data;  // most recent winner was load/store
  logic        e_mv, e_we, e_ir, e_dr, e_ierr, e_derr;
  logic [31:0] e_addr, e_wd, e_ird, e_drd;
  logic [3:0]  e_ws;

  task automatic model_reset();
    m_owner = 0; m_elapsed = 0; m_last_data = 1'b1;
    e_mv = 0; e_we = 0; e_ir = 0; e_dr = 0; e_ierr = 0; e_derr = 0;
    e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0; e_ws = 0;
  endtask

  task automatic model_step();
    bit ir_now, dr_now, done, err, want_i, want_d;
    int pick;
    ir_now = e_ir; dr_now = e_dr;
    e_ir = 0; e_dr = 0;
    done = 0; err = 0; pick = 0;
    if (m_owner != 0) begin
      if (bus.mem_ready) done = 1;
      else begin
        m_elapsed++;
        if (m_elapsed == TMO) begin done = 1; err = 1; end
      end
      if (done) begin
        e_mv = 0;
        if (m_owner == 1) begin
          e_ir = 1; e_ierr = err; e_ird = err ? 32'h0 : bus.mem_rdata;
        end else begin
          e_dr = 1; e_derr = err; e_drd = (err || e_we) ? 32'h0 : bus.mem_rdata;
        end
        m_owner = 0;
      end
    end else if (!halt) begin
      want_i = bus.i_req && !ir_now;
      want_d = bus.d_req && !dr_now;
      if (want_i && want_d) pick = m_last_data ? 1 : 2;
      else if (want_i)      pick = 1;
      else if (want_d)      pick = 2;
      if (pick != 0) begin
        m_owner = pick; m_last_data = (pick == 2); m_elapsed = 0; e_mv = 1;
        if (pick == 1) begin
          e_addr = bus.i_addr; e_we = 0; e_wd = 0; e_ws = 0;
        end else begin
          e_addr = bus.d_addr; e_we = bus.d_we; e_wd = bus.d_wdata; e_ws = bus.d_wstrb;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    halt = 0;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
  endtask

  bit pend_i, pend_d;

  initial begin
    // columns: halt,i_req,i_addr,d_req,d_we,d_addr,d_wdata,mem_ready,mem_rdata | mv,addr,we,wdata,i_rdy,d_rdy,rdata,err,idle
    tbl[0]  = '{0,1,'h100,1,0,'h2000,0,0,0,                   1,'h100,0,0,0,0,0,0,0};
    tbl[1]  = '{0,1,'h100,1,0,'h2000,0,1,'hDEADBEEF,          0,0,0,0,1,0,'hDEADBEEF,0,0};
    tbl[2]  = '{0,1,'h100,1,0,'h2000,0,0,0,                   1,'h2000,0,0,0,0,0,0,0};
    tbl[3]  = '{0,1,'h104,1,0,'h2000,0,1,'hCAFEF00D,          0,0,0,0,0,1,'hCAFEF00D,0,0};
    tbl[4]  = '{0,1,'h104,1,0,'h2000,0,0,0,                   1,'h104,0,0,0,0,0,0,0};
    tbl[5]  = '{0,1,'h104,1,0,'h2008,0,1,'h11111111,          0,0,0,0,1,0,'h11111111,0,0};
    tbl[6]  = '{0,1,'h104,1,0,'h2008,0,0,0,                   1,'h2008,0,0,0,0,0,0,0};
    tbl[7]  = '{0,0,0,1,0,'h2008,0,1,'h22222222,              0,0,0,0,0,1,'h22222222,0,0};
    tbl[8]  = '{0,0,0,1,0,'h2008,0,0,0,                       0,0,0,0,0,0,0,0,1};
    tbl[9]  = '{0,0,0,1,1,'h3000,'h12345678,0,0,              1,'h3000,1,'h12345678,0,0,0,0,0};
    tbl[10] = '{0,0,0,1,1,'h3000,'h12345678,0,0,              1,'h3000,1,'h12345678,0,0,0,0,0};
    tbl[11] = '{0,0,0,1,1,'h3000,'h12345678,0,0,              1,'h3000,1,'h12345678,0,0,0,0,0};
    tbl[12] = '{0,0,0,1,1,'h3000,'h12345678,0,0,              1,'h3000,1,'h12345678,0,0,0,0,0};
    tbl[13] = '{0,0,0,1,1,'h3000,'h12345678,1,'hFFFFFFFF,     0,0,0,0,0,1,0,0,0};
    tbl[14] = '{0,0,0,1,1,'h3000,'h12345678,0,0,              0,0,0,0,0,0,0,0,1};
    tbl[15] = '{0,0,0,1,0,'h4000,0,0,0,                       1,'h4000,0,0,0,0,0,0,0};
    tbl[16] = '{0,0,0,1,0,'h4000,0,0,0,                       1,'h4000,0,0,0,0,0,0,0};
    tbl[17] = '{0,0,0,1,0,'h4000,0,0,0,                       1,'h4000,0,0,0,0,0,0,0};
    tbl[18] = '{0,0,0,1,0,'h4000,0,0,0,                       1,'h4000,0,0,0,0,0,0,0};
    tbl[19] = '{0,0,0,1,0,'h4000,0,0,0,                       0,0,0,0,0,1,0,1,0};
    tbl[20] = '{0,0,0,1,0,'h4000,0,0,0,                       0,0,0,0,0,0,0,0,1};
    tbl[21] = '{1,1,'h500,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,1};
    tbl[22] = '{1,1,'h500,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,1};
    tbl[23] = '{0,1,'h500,0,0,0,0,0,0,                        1,'h500,0,0,0,0,0,0,0};
    tbl[24] = '{0,1,'h500,0,0,0,0,1,'h55,                     0,0,0,0,1,0,'h55,0,0};
    tbl[25] = '{0,0,0,1,0,'h6000,0,0,0,                       1,'h6000,0,0,0,0,0,0,0};
    tbl[26] = '{1,0,0,1,0,'h6000,0,0,0,                       1,'h6000,0,0,0,0,0,0,0};
    tbl[27] = '{1,0,0,1,0,'h6000,0,1,'h66,                    0,0,0,0,0,1,'h66,0,0};
    tbl[28] = '{1,1,'h504,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,1};
    tbl[29] = '{1,1,'h504,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,1};
    tbl[30] = '{0,1,'h504,0,0,0,0,0,0,                        1,'h504,0,0,0,0,0,0,0};
    tbl[31] = '{0,1,'h504,0,0,0,0,1,'h77,                     0,0,0,0,1,0,'h77,0,0};
    tbl[32] = '{0,0,0,0,0,0,0,0,0,                            0,0,0,0,0,0,0,0,1};
    tbl[33] = '{0,0,0,0,0,0,0,1,'h99,                         0,0,0,0,0,0,0,0,1};

    // ---------------- reset state ----------------
    reset = 1'b1;
    clear_inputs();
    #12;
    chk("reset mem_valid", bus.mem_valid, 1'b0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset i_ready", bus.i_ready, 1'b0);
    chk("reset d_ready", bus.d_ready, 1'b0);
    chk("reset idle", idle, 1'b1);
    reset = 1'b0;

    // ---------------- directed vector table ----------------
    for (int i = 0; i < NROW; i++) begin
      halt          = tbl[i].halt;
      bus.i_req     = tbl[i].i_req;
      bus.i_addr    = tbl[i].i_addr;
      bus.d_req     = tbl[i].d_req;
      bus.d_we      = tbl[i].d_we;
      bus.d_addr    = tbl[i].d_addr;
      bus.d_wdata   = tbl[i].d_wdata;
      bus.d_wstrb   = tbl[i].d_we ? 4'hF : 4'h0;
      bus.mem_ready = tbl[i].mem_ready;
      bus.mem_rdata = tbl[i].mem_rdata;
      @(posedge clk); #1;
      chk($sformatf("r%0d mem_valid", i), bus.mem_valid, tbl[i].e_mv);
      if (tbl[i].e_mv)
        chk($sformatf("r%0d mem_req", i), {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb},
            {tbl[i].e_addr, tbl[i].e_we, tbl[i].e_wd, (tbl[i].e_we ? 4'hF : 4'h0)});
      chk($sformatf("r%0d i_ready", i), bus.i_ready, tbl[i].e_ir);
      chk($sformatf("r%0d d_ready", i), bus.d_ready, tbl[i].e_dr);
      if (tbl[i].e_ir)
        chk($sformatf("r%0d i_resp", i), {bus.i_rdata, bus.i_err}, {tbl[i].e_rd, tbl[i].e_err});
      if (tbl[i].e_dr)
        chk($sformatf("r%0d d_resp", i), {bus.d_rdata, bus.d_err}, {tbl[i].e_rd, tbl[i].e_err});
      chk($sformatf("r%0d idle", i), idle, tbl[i].e_idle);
    end

    // ---------------- asynchronous reset in the middle of a fetch ----------------
    clear_inputs();
    bus.i_req = 1; bus.i_addr = 32'h700;
    @(posedge clk); #1;
    chk("rst_seq grant mem_valid", bus.mem_valid, 1'b1);
    chk("rst_seq grant mem_addr", bus.mem_addr, 32'h700);
    #2 reset = 1'b1;
    #1;
    chk("rst_seq async mem_valid", bus.mem_valid, 1'b0);
    chk("rst_seq async mem_addr", bus.mem_addr, 32'h0);
    chk("rst_seq async idle", idle, 1'b1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    chk("rst_seq no i_ready", bus.i_ready, 1'b0);
    chk("rst_seq held idle", idle, 1'b1);
    reset = 1'b0;
    bus.mem_ready = 0;
    bus.i_addr = 32'h800; bus.d_req = 1; bus.d_addr = 32'h900;
    @(posedge clk); #1;
    chk("rst_seq tie to fetch", {bus.mem_valid, bus.mem_addr}, {1'b1, 32'h800});
    bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("rst_seq fetch done", {bus.i_ready, bus.i_rdata, bus.i_err}, {1'b1, 32'hA5A5A5A5, 1'b0});

    // ---------------- randomized run against the model ----------------
    clear_inputs();
    reset = 1'b1;
    #3 reset = 1'b0;
    model_reset();
    pend_i = 0; pend_d = 0;
    for (int c = 0; c < 3000; c++) begin
      // requesters keep their lines through the ready cycle, then decide afresh
      if (e_ir) pend_i = 0;
      else if (!pend_i) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.i_req = 1; bus.i_addr = $urandom; pend_i = 1;
        end else bus.i_req = 0;
      end
      if (e_dr) pend_d = 0;
      else if (!pend_d) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom;
          bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom_range(0, 15)); pend_d = 1;
        end else bus.d_req = 0;
      end
      halt          = ($urandom_range(0, 7) == 0);
      bus.mem_ready = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d mem_valid", c), bus.mem_valid, e_mv);
      if (e_mv)
        chk($sformatf("rnd%0d mem_req", c), {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb},
            {e_addr, e_we, e_wd, e_ws});
      chk($sformatf("rnd%0d readys", c), {bus.i_ready, bus.d_ready}, {e_ir, e_dr});
      if (e_ir) chk($sformatf("rnd%0d i_resp", c), {bus.i_rdata, bus.i_err}, {e_ird, e_ierr});
      if (e_dr) chk($sformatf("rnd%0d d_resp", c), {bus.d_rdata, bus.d_err}, {e_drd, e_derr});
      chk($sformatf("rnd%0d idle", c), idle, (m_owner == 0) && !e_ir && !e_dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
